axi_rd_strided_mstr: RTL and testbench

//  AXI4 read master between the LSU and DRAM slave; next-generation strided read engine.
//  - One LSU request becomes SEG_NUM AR bursts at base + i*stride.
//  - Up to OUTSTD bursts are in flight; each uses a tracking slot whose index is its ARID.
//  - R beats pass to the LSU through a FIFO that honours LSU backpressure via RREADY.
//  - Pulses done, with an aggregated error flag, when every burst has returned RLAST.

---
 rtl/axi_rd_pkg.sv | 34 +++
 rtl/axi_rd_strided_mstr_if.sv | 42 ++++
 rtl/axi_rd_fifo.sv | 58 +++++
 rtl/axi_rd_strided_mstr.sv | 199 +++++++++++++++++++
 tb/tb_axi_rd_strided_mstr.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_rd_pkg.sv
// ============================================================================
// axi_rd_pkg : shared AXI encodings, FSM state type and stride decode
// Rev 1.0
// ============================================================================
`default_nettype none

package axi_rd_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Selects 0..4 give 16..256 byte strides; 5..7 re-read the same address.
  function automatic logic [8:0] stride_decode(input logic [2:0] sel);
    logic [8:0] s;
    s = 9'd0;
    if (sel <= 3'd4) s = 9'd16 << sel;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_rd_strided_mstr_if.sv
// ============================================================================
// axi_rd_strided_mstr_if : AXI4 AR + R channel bundle with master/slave views
// Rev 1.0
// ============================================================================
`default_nettype none

interface axi_rd_strided_mstr_if #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

`default_nettype wire

// File: rtl/axi_rd_fifo.sv
// ============================================================================
// axi_rd_fifo : synchronous FIFO, simultaneous push/pop allowed even when full
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_rd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CNT_W'(DEPTH));
  assign do_pop     = pop_i & ~empty_o;
  assign do_push    = push_i & (~full_o | do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

`default_nettype wire

// File: rtl/axi_rd_strided_mstr.sv
// ============================================================================
// axi_rd_strided_mstr : strided AXI4 read master; AXI_RD_ERR_CNT_EN adds err_cnt_o
// Rev 1.0
// ============================================================================
`default_nettype none

module axi_rd_strided_mstr
  import axi_rd_pkg::*;
#(
  parameter int ID_W      = 4,
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 64,
  parameter int OUTSTD    = 4,
  parameter int BUF_DEPTH = 4,
  parameter int SEG_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_vld_i,
  output logic              req_rdy_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [7:0]        req_len_i,
  input  logic [2:0]        req_size_i,
  input  logic [1:0]        req_burst_i,
  input  logic [2:0]        req_str_i,
  input  logic [SEG_W-1:0]  req_seg_i,
  axi_rd_strided_mstr_if.master axi,
  output logic              rd_vld_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [1:0]        rd_resp_o,
  output logic              rd_last_o,
  output logic [ID_W-1:0]   rd_id_o,
  input  logic              rd_rdy_i,
  output logic              done_o,
  output logic              done_err_o
`ifdef AXI_RD_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt_o
`endif
);

  localparam int FIFO_W = ID_W + DATA_W + 3;

  state_e            state_q;
  logic              req_rdy_q, arvalid_q, done_q, done_err_q, err_q;
  logic [ID_W-1:0]   arid_q;
  logic [ADDR_W-1:0] araddr_q, cur_addr_q, stride_q;
  logic [7:0]        arlen_q;
  logic [2:0]        arsize_q;
  logic [1:0]        arburst_q;
  logic [SEG_W-1:0]  seg_num_q, seg_cnt_q;
  logic [OUTSTD-1:0] busy_q;

  logic              ar_hs, r_hs, r_hit, r_bad, free_any;
  logic              fifo_full, fifo_empty;
  logic [OUTSTD-1:0] busy_d;
  logic [ID_W-1:0]   free_id;
  logic [SEG_W-1:0]  seg_cnt_d;
  logic [ADDR_W-1:0] addr_d;
  logic [FIFO_W-1:0] fifo_out;

  assign ar_hs      = arvalid_q & axi.arready;
  assign axi.rready = ~fifo_full & ~rst;
  assign r_hs       = axi.rvalid & axi.rready;
  assign r_bad      = r_hs & ((axi.rresp != RESP_OKAY) | ~r_hit);
  assign seg_cnt_d  = seg_cnt_q + 1'b1;
  assign addr_d     = cur_addr_q + stride_q;

  // Slot occupancy after this cycle's RLAST release and AR allocation; allocation wins.
  always_comb begin
    r_hit    = 1'b0;
    busy_d   = busy_q;
    free_any = 1'b0;
    free_id  = '0;
    for (int i = 0; i < OUTSTD; i++) begin
      if (axi.rid == ID_W'(i) && busy_q[i]) r_hit = 1'b1;
      if (r_hs && axi.rlast && axi.rid == ID_W'(i)) busy_d[i] = 1'b0;
      if (ar_hs && arid_q == ID_W'(i)) busy_d[i] = 1'b1;
    end
    for (int i = OUTSTD - 1; i >= 0; i--) begin
      if (!busy_d[i]) begin
        free_any = 1'b1;
        free_id  = ID_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_rdy_q  <= 1'b0;
      arvalid_q  <= 1'b0;
      arid_q     <= '0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
      cur_addr_q <= '0;
      stride_q   <= '0;
      seg_num_q  <= '0;
      seg_cnt_q  <= '0;
      busy_q     <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
      busy_q     <= busy_d;
      if (r_bad) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          req_rdy_q <= 1'b1;
          if (req_vld_i && req_rdy_q) begin
            req_rdy_q  <= 1'b0;
            arlen_q    <= req_len_i;
            arsize_q   <= req_size_i;
            arburst_q  <= req_burst_i;
            stride_q   <= ADDR_W'(stride_decode(req_str_i));
            seg_num_q  <= (req_seg_i == '0) ? SEG_W'(1) : req_seg_i;
            seg_cnt_q  <= '0;
            cur_addr_q <= req_addr_i;
            araddr_q   <= req_addr_i;
            arid_q     <= free_id;
            arvalid_q  <= free_any;
            err_q      <= 1'b0;
            state_q    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (ar_hs) begin
            seg_cnt_q  <= seg_cnt_d;
            cur_addr_q <= addr_d;
            araddr_q   <= addr_d;
            if (seg_cnt_d == seg_num_q) begin
              arvalid_q <= 1'b0;
              state_q   <= ST_DRAIN;
            end else begin
              arvalid_q <= free_any;
              arid_q    <= free_id;
            end
          end else if (!arvalid_q) begin
            // ARID is only chosen while ARVALID is low, so a stalled AR never re-picks.
            arvalid_q <= free_any;
            arid_q    <= free_id;
          end
        end
        ST_DRAIN: begin
          if (busy_d == '0) begin
            done_q     <= 1'b1;
            done_err_q <= err_q | r_bad;
            req_rdy_q  <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef AXI_RD_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else if (r_bad && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign err_cnt_o = err_cnt_q;
`endif

  axi_rd_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (r_hs),
    .push_data_i ({axi.rid, axi.rdata, axi.rresp, axi.rlast}),
    .pop_i       (rd_vld_o & rd_rdy_i),
    .pop_data_o  (fifo_out),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign rd_vld_o    = ~fifo_empty;
  assign {rd_id_o, rd_data_o, rd_resp_o, rd_last_o} = fifo_out;

  assign req_rdy_o   = req_rdy_q;
  assign axi.arvalid = arvalid_q;
  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = arburst_q;
  assign done_o      = done_q;
  assign done_err_o  = done_err_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_rd_strided_mstr.sv
// ============================================================================
// tb_axi_rd_strided_mstr : scoreboard bench for the strided AXI read master
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_axi_rd_strided_mstr;
  import axi_rd_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_vld, req_rdy;
  logic [9:0] req_addr;
  logic [7:0] req_len;
  logic [2:0] req_size, req_str;
  logic [1:0] req_burst;
  logic [3:0] req_seg;
  logic        rd_vld, rd_last, rd_rdy, done, done_err;
  logic [63:0] rd_data;
  logic [1:0]  rd_resp;
  logic [3:0]  rd_id;
`ifdef AXI_RD_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  axi_rd_strided_mstr_if #(.ID_W(4), .ADDR_W(10), .DATA_W(64)) axi ();

  axi_rd_strided_mstr #(
    .ID_W(4), .ADDR_W(10), .DATA_W(64), .OUTSTD(4), .BUF_DEPTH(4), .SEG_W(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_addr_i(req_addr),
    .req_len_i(req_len), .req_size_i(req_size), .req_burst_i(req_burst),
    .req_str_i(req_str), .req_seg_i(req_seg),
    .axi(axi),
    .rd_vld_o(rd_vld), .rd_data_o(rd_data), .rd_resp_o(rd_resp),
    .rd_last_o(rd_last), .rd_id_o(rd_id), .rd_rdy_i(rd_rdy),
    .done_o(done), .done_err_o(done_err)
`ifdef AXI_RD_ERR_CNT_EN
    , .err_cnt_o(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [3:0] id; logic [9:0] addr; } ar_t;
  typedef struct packed { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } beat_t;

  ar_t   exp_ar[$];
  beat_t exp_beat[$];
  bit    exp_done[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    done_cnt = 0;
  logic [7:0] cur_len = 8'd0;
  ar_t   ea;
  beat_t eb;
  bit    ed;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observes handshakes on the falling edge, ahead of the rising edge that completes them.
  always @(negedge clk) begin
    if (!rst) begin
      if (axi.arvalid && axi.arready) begin
        chk("ar_expected", exp_ar.size() != 0, 1);
        if (exp_ar.size() != 0) begin
          ea = exp_ar.pop_front();
          chk("arid", axi.arid, ea.id);
          chk("araddr", axi.araddr, ea.addr);
          chk("arlen", axi.arlen, cur_len);
        end
      end
      if (rd_vld && rd_rdy) begin
        chk("beat_expected", exp_beat.size() != 0, 1);
        if (exp_beat.size() != 0) begin
          eb = exp_beat.pop_front();
          chk("rd_beat", {rd_id, rd_data, rd_resp, rd_last}, eb);
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_expected", exp_done.size() != 0, 1);
        if (exp_done.size() != 0) begin
          ed = exp_done.pop_front();
          chk("done_err", done_err, ed);
        end
      end
      if (axi.rvalid && axi.rready)
        exp_beat.push_back({axi.rid, axi.rdata, axi.rresp, axi.rlast});
    end
  end

  task automatic send_req(input logic [9:0] a, input logic [7:0] len,
                          input logic [2:0] str, input logic [3:0] seg);
    int n = 0;
    while (!req_rdy && n < 100) begin tick(); n++; end
    chk("req_rdy_wait", req_rdy, 1);
    req_addr = a; req_len = len; req_str = str; req_seg = seg;
    req_size = 3'd3; req_burst = BURST_INCR; cur_len = len;
    req_vld = 1'b1;
    tick();
    req_vld = 1'b0;
  endtask

  task automatic push_ar(input logic [3:0] id, input logic [9:0] a);
    exp_ar.push_back({id, a});
  endtask

  task automatic wait_ar_drain();
    int n = 0;
    while (exp_ar.size() != 0 && n < 100) begin tick(); n++; end
    chk("ar_drain", exp_ar.size(), 0);
  endtask

  task automatic send_r(input logic [3:0] id, input logic [63:0] d,
                        input logic [1:0] resp, input logic last);
    int n = 0;
    axi.rid = id; axi.rdata = d; axi.rresp = resp; axi.rlast = last;
    axi.rvalid = 1'b1;
    @(negedge clk);
    while (!axi.rready && n < 200) begin @(negedge clk); n++; end
    chk("r_accept", axi.rready, 1);
    tick();
    axi.rvalid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    int start = done_cnt;
    while (done_cnt == start && n < 200) begin tick(); n++; end
    chk("done_seen", done_cnt > start, 1);
  endtask

  initial begin
    rst = 1'b1; req_vld = 1'b0; req_addr = '0; req_len = '0; req_size = '0;
    req_burst = '0; req_str = '0; req_seg = '0; rd_rdy = 1'b1;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rid = '0; axi.rdata = '0;
    axi.rresp = RESP_OKAY; axi.rlast = 1'b0;
    repeat (3) tick();
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_arvalid", axi.arvalid, 0);
    chk("rst_rready", axi.rready, 0);
    chk("rst_rd_vld", rd_vld, 0);
    chk("rst_done", done, 0);
    chk("rst_araddr", axi.araddr, 0);
    rst = 1'b0;
    tick();
    chk("req_rdy_post_rst", req_rdy, 1);

    // Three 16-byte-strided single-beat bursts.
    axi.arready = 1'b1;
    push_ar(4'd0, 10'h040); push_ar(4'd1, 10'h050); push_ar(4'd2, 10'h060);
    exp_done.push_back(1'b0);
    send_req(10'h040, 8'd0, 3'd0, 4'd3);
    chk("first_arvalid", axi.arvalid, 1);
    wait_ar_drain();
    send_r(4'd0, 64'hA, RESP_OKAY, 1'b1);
    send_r(4'd1, 64'hB, RESP_OKAY, 1'b1);
    send_r(4'd2, 64'hC, RESP_OKAY, 1'b1);
    wait_done();

    // Six segments against four slots with R withheld.
    for (int i = 0; i < 4; i++) push_ar(4'(i), 10'h100 + 10'(16 * i));
    exp_done.push_back(1'b0);
    send_req(10'h100, 8'd0, 3'd0, 4'd6);
    wait_ar_drain();
    repeat (5) tick();
    chk("ar_held_low", axi.arvalid, 0);
    push_ar(4'd1, 10'h140);
    send_r(4'd1, 64'h11, RESP_OKAY, 1'b1);
    wait_ar_drain();
    push_ar(4'd0, 10'h150);
    send_r(4'd0, 64'h10, RESP_OKAY, 1'b1);
    wait_ar_drain();
    send_r(4'd2, 64'h22, RESP_OKAY, 1'b1);
    send_r(4'd3, 64'h33, RESP_OKAY, 1'b1);
    send_r(4'd1, 64'h41, RESP_OKAY, 1'b1);
    send_r(4'd0, 64'h40, RESP_OKAY, 1'b1);
    wait_done();

    // LSU stall: FIFO fills, RREADY drops, then drains in order.
    rd_rdy = 1'b0;
    push_ar(4'd0, 10'h200); push_ar(4'd1, 10'h220); push_ar(4'd2, 10'h240);
    exp_done.push_back(1'b0);
    send_req(10'h200, 8'd1, 3'd1, 4'd3);
    wait_ar_drain();
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_r(4'(i / 2), 64'hD00 + 64'(i), RESP_OKAY, i[0]);
      end
      begin
        repeat (10) tick();
        chk("rready_full", axi.rready, 0);
        chk("rd_vld_full", rd_vld, 1);
        rd_rdy = 1'b1;
      end
    join
    wait_done();

    // Address arithmetic wraps modulo 2**ADDR_W.
    cur_len = 8'd0;
    push_ar(4'd0, 10'h3F0); push_ar(4'd1, 10'h000);
    exp_done.push_back(1'b0);
    send_req(10'h3F0, 8'd0, 3'd0, 4'd2);
    wait_ar_drain();
    send_r(4'd0, 64'h3F0, RESP_OKAY, 1'b1);
    send_r(4'd1, 64'h000, RESP_OKAY, 1'b1);
    wait_done();

    // SLVERR on one burst plus a beat with an unallocated RID.
    push_ar(4'd0, 10'h080); push_ar(4'd1, 10'h0C0);
    exp_done.push_back(1'b1);
    send_req(10'h080, 8'd0, 3'd2, 4'd2);
    wait_ar_drain();
    send_r(4'd0, 64'hE0, RESP_SLVERR, 1'b1);
    send_r(4'd5, 64'hE5, RESP_OKAY, 1'b1);
    send_r(4'd1, 64'hE1, RESP_OKAY, 1'b1);
    wait_done();
`ifdef AXI_RD_ERR_CNT_EN
    chk("err_cnt", err_cnt, 16'd2);
`endif

    // Reset in ISSUE with two bursts in flight.
    for (int i = 0; i < 4; i++) push_ar(4'(i), 10'(16 * i));
    send_req(10'h000, 8'd0, 3'd0, 4'd4);
    for (int n = 0; n < 50 && exp_ar.size() > 2; n++) tick();
    axi.arready = 1'b0;
    chk("two_in_flight", exp_ar.size(), 2);
    rst = 1'b1;
    exp_ar.delete();
    tick();
    chk("midrst_arvalid", axi.arvalid, 0);
    chk("midrst_rd_vld", rd_vld, 0);
    chk("midrst_req_rdy", req_rdy, 0);
    rst = 1'b0;
    tick();
    chk("midrst_req_rdy_after", req_rdy, 1);

    axi.arready = 1'b1;
    push_ar(4'd0, 10'h010);
    exp_done.push_back(1'b0);
    send_req(10'h010, 8'd0, 3'd0, 4'd0);
    wait_ar_drain();
    send_r(4'd0, 64'hF0, RESP_OKAY, 1'b1);
    wait_done();

    for (int n = 0; n < 50 && exp_beat.size() != 0; n++) tick();
    chk("beats_left", exp_beat.size(), 0);
    chk("dones_left", exp_done.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
